// File: rtl/tag_serial_scheduler.sv
// Round-robin scheduler that serializes per-channel phase tags
// as {channel, tag} frames on a divided bit clock.
module tag_serial_scheduler #(
  parameter int NUM_CH = 4,
  parameter int TAG_W  = 16,
  parameter int DIV    = 4
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic [NUM_CH*TAG_W-1:0] tag_in,
  input  logic [NUM_CH-1:0]       tag_valid,
  input  logic                    clear_drop,
  output logic [NUM_CH-1:0]       tag_drop,
  output logic                    serial_clk,
  output logic                    serial_out,
  output logic                    serial_valid,
  output logic                    busy
);

  localparam int CH_W    = $clog2(NUM_CH);
  localparam int FRAME_W = CH_W + TAG_W;
  localparam int BC_W    = $clog2(FRAME_W);
  localparam int PH_W    = $clog2(DIV);

  localparam logic [BC_W-1:0] BC_LAST = BC_W'(FRAME_W - 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DIV - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(DIV / 2);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t             r_state;
  logic [FRAME_W-1:0] r_sr;
  logic [BC_W-1:0]    r_bit;
  logic [PH_W-1:0]    r_ph;
  logic [CH_W-1:0]    r_last;
  logic [NUM_CH-1:0]  r_pend;
  logic [NUM_CH-1:0]  r_drop;
  logic [TAG_W-1:0]   r_hold [NUM_CH];

  logic              w_found;
  logic              w_grant;
  logic [CH_W-1:0]   w_gidx;
  logic [CH_W:0]     w_sum;
  logic [CH_W-1:0]   w_idx;
  logic [NUM_CH-1:0] w_gnt;
  logic [NUM_CH-1:0] w_cap;
  logic [NUM_CH-1:0] w_drop;

  // Search starts just past the last grant and wraps around
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_sum = {1'b0, r_last} + (CH_W+1)'(k);
      if (w_sum >= (CH_W+1)'(NUM_CH))
        w_sum = w_sum - (CH_W+1)'(NUM_CH);
      w_idx = w_sum[CH_W-1:0];
      if (!w_found && r_pend[w_idx]) begin
        w_found = 1'b1;
        w_gidx  = w_idx;
      end
    end
  end

  assign w_grant = (r_state == IDLE) && w_found;
  assign w_gnt   = w_grant ? (NUM_CH'(1) << w_gidx) : '0;
  assign w_cap   = {NUM_CH{rst}} & tag_valid & (~r_pend | w_gnt);
  assign w_drop  = {NUM_CH{rst}} & tag_valid & r_pend & ~w_gnt;

  always_ff @(posedge sys_clk) begin
    for (int i = 0; i < NUM_CH; i++)
      if (w_cap[i])
        r_hold[i] <= tag_in[i*TAG_W +: TAG_W];
  end

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      r_pend <= '0;
      r_drop <= '0;
    end else begin
      r_pend <= (r_pend & ~w_gnt) | w_cap;
      if (clear_drop)
        r_drop <= w_drop;
      else
        r_drop <= r_drop | w_drop;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_bit   <= '0;
      r_ph    <= '0;
      r_last  <= CH_W'(NUM_CH - 1);
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_found) begin
            r_sr    <= {w_gidx, r_hold[w_gidx]};
            r_last  <= w_gidx;
            r_bit   <= '0;
            r_ph    <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (r_ph == PH_LAST) begin
            r_ph <= '0;
            r_sr <= {r_sr[FRAME_W-2:0], 1'b0};
            if (r_bit == BC_LAST) begin
              r_bit   <= '0;
              r_state <= GAP;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_ph <= r_ph + 1'b1;
          end
        end
        GAP: begin
          if (r_ph == PH_LAST) begin
            r_ph    <= '0;
            r_state <= IDLE;
          end else begin
            r_ph <= r_ph + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign serial_valid = (r_state == SHIFT);
  assign serial_out   = serial_valid & r_sr[FRAME_W-1];
  assign serial_clk   = serial_valid & (r_ph >= PH_HALF);
  assign busy         = (r_state != IDLE);
  assign tag_drop     = r_drop;

endmodule
